// File: rtl/tron_fetch_pkg.sv
// tron_fetch_pkg -- shared types and constants for the TRON instruction fetch unit.
//   fetch_state_e : fetch FSM states (IDLE, REQ, WAIT, DROP)
//   NOP           : instruction presented to the core when the buffer is empty
//   DEFAULT_DEPTH : default instruction-buffer depth
//   pc_inc        : 16-bit PC increment, wrapping FFFF -> 0000
package tron_fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DROP = 2'd3
   } fetch_state_e;

   localparam logic [15:0] NOP           = 16'h0000;
   localparam int          DEFAULT_DEPTH = 2;

   function automatic logic [15:0] pc_inc(input logic [15:0] pc);
      return pc + 16'd1;
   endfunction

endpackage

// File: rtl/tron_fetch_fifo.sv
// tron_fetch_fifo -- instruction buffer for the fetch unit.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   flush       : empties the buffer; wins over push/pop in the same cycle
//   push, wdata : write an entry (ignored when full)
//   pop         : retire the head entry (ignored when empty)
//   rdata       : head entry, NOP when empty
//   full, empty : occupancy flags
//   count       : number of valid entries
// DEPTH must be a power of two so the pointers wrap naturally.
module tron_fetch_fifo
   import tron_fetch_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int              AW       = $clog2(DEPTH);
   localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;  // idle, or push+pop leaves occupancy unchanged
         endcase
      end
   end

   // Storage needs no reset: entries are only visible through count.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign rdata = empty ? NOP : mem[rd_ptr];

endmodule

// File: rtl/tron_fetch_unit.sv
// tron_fetch_unit -- instruction fetch front end for the TRON core.
// Keeps a small instruction buffer topped up from a request/grant/rvalid memory
// port with at most one read outstanding, and handles redirects (pc_load).
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   pc_in, pc_load             : redirect target and strobe
//   mem_req, mem_addr          : read request and word address (= fetch_pc)
//   mem_gnt                    : request accepted this cycle
//   mem_rvalid, mem_rdata      : read response
//   instruction, instr_valid   : buffer head to the core (NOP when empty)
//   instr_ready                : core consumes the head this cycle
// Optional: define TRON_FETCH_PERF_EN to add saturating counters
//   fetch_cnt (buffer pushes) and stall_cnt (ready while starved).
module tron_fetch_unit
   import tron_fetch_pkg::*;
#(
   parameter int          DEPTH    = DEFAULT_DEPTH,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] pc_in,
   input  logic        pc_load,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [15:0] mem_rdata,
   output logic [15:0] instruction,
   output logic        instr_valid,
   input  logic        instr_ready
`ifdef TRON_FETCH_PERF_EN
  ,output logic [15:0] fetch_cnt,
   output logic [15:0] stall_cnt
`endif
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
   localparam logic [AW:0] DEPTH_M1 = (AW+1)'(DEPTH - 1);

   fetch_state_e state;
   logic [15:0]  fetch_pc;
   logic [AW:0]  buf_count;
   logic         buf_full;
   logic         buf_empty;
   logic         push;
   logic         pop;
   logic         space_after_push;

   // Responses are only accepted while a request is genuinely outstanding;
   // a redirect in the same cycle throws the data away.
   assign push = (state == ST_WAIT) && mem_rvalid && !pc_load && !buf_full;
   assign pop  = instr_valid && instr_ready && !pc_load;

   // Occupancy after this cycle's push is count+1-pop; room remains when
   // that is below DEPTH.
   assign space_after_push = pop || (buf_count < DEPTH_M1);

   assign instr_valid = !buf_empty;
   assign mem_addr    = fetch_pc;

   tron_fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (16)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (pc_load),
      .push  (push),
      .wdata (mem_rdata),
      .pop   (pop),
      .rdata (instruction),
      .full  (buf_full),
      .empty (buf_empty),
      .count (buf_count)
   );

   // Fetch FSM. mem_req is registered and set exactly when entering/staying in REQ.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         fetch_pc <= RESET_PC;
         mem_req  <= 1'b0;
      end else begin
         mem_req <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pc_load) begin
                  fetch_pc <= pc_in;
                  state    <= ST_REQ;
                  mem_req  <= 1'b1;
               end else if (buf_count < DEPTH_C) begin
                  state    <= ST_REQ;
                  mem_req  <= 1'b1;
               end
            end

            ST_REQ: begin
               if (pc_load) begin
                  fetch_pc <= pc_in;
                  if (mem_gnt) begin
                     // The granted read is now stale; its data must be eaten.
                     state <= ST_DROP;
                  end else begin
                     state   <= ST_REQ;
                     mem_req <= 1'b1;
                  end
               end else if (mem_gnt) begin
                  fetch_pc <= pc_inc(fetch_pc);
                  state    <= ST_WAIT;
               end else begin
                  mem_req  <= 1'b1;
               end
            end

            ST_WAIT: begin
               if (pc_load) begin
                  fetch_pc <= pc_in;
                  if (mem_rvalid) begin
                     // The stale response retires in this very cycle, so
                     // nothing is left to drop.
                     state   <= ST_REQ;
                     mem_req <= 1'b1;
                  end else begin
                     state   <= ST_DROP;
                  end
               end else if (mem_rvalid) begin
                  if (space_after_push) begin
                     state   <= ST_REQ;
                     mem_req <= 1'b1;
                  end else begin
                     state   <= ST_IDLE;
                  end
               end
            end

            ST_DROP: begin
               if (pc_load) fetch_pc <= pc_in;
               if (mem_rvalid) begin
                  state   <= ST_REQ;
                  mem_req <= 1'b1;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef TRON_FETCH_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (push && (fetch_cnt != 16'hFFFF))
            fetch_cnt <= fetch_cnt + 16'd1;
         if (instr_ready && !instr_valid && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tron_fetch_unit.sv
module tb_tron_fetch_unit;
   import tron_fetch_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] pc_in;
   logic        pc_load;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [15:0] mem_rdata;
   logic [15:0] instruction;
   logic        instr_valid;
   logic        instr_ready;

   // second instance for the RESET_PC wrap case, memory always grants
   logic        req_w;
   logic [15:0] addr_w;
   logic        gnt_w;
   logic        rv_w = 1'b0;
   logic [15:0] rd_w = 16'h0;
   logic [15:0] ins_w;
   logic        vld_w;
   logic        rdy_w;

`ifdef TRON_FETCH_PERF_EN
   logic [15:0] fetch_cnt, stall_cnt, fetch_cnt_w, stall_cnt_w;
`endif

   logic        gnt_en, auto_en, man_rv;
   logic [15:0] man_rd;
   logic        auto_rv = 1'b0;
   logic [15:0] auto_rd = 16'h0;

   int n_chk  = 0;
   int n_fail = 0;

   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   function automatic logic [15:0] memf(input logic [15:0] a);
      return (a * 16'd7) ^ 16'h5A3C;
   endfunction

   assign mem_gnt    = mem_req & gnt_en;
   assign mem_rvalid = auto_rv | man_rv;
   assign mem_rdata  = man_rv ? man_rd : auto_rd;
   assign gnt_w      = req_w;

   tron_fetch_unit #(.DEPTH(2), .RESET_PC(16'h0000)) dut (
      .clk(clk), .reset(reset), .pc_in(pc_in), .pc_load(pc_load),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .instruction(instruction), .instr_valid(instr_valid), .instr_ready(instr_ready)
`ifdef TRON_FETCH_PERF_EN
     ,.fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
   );

   tron_fetch_unit #(.DEPTH(2), .RESET_PC(16'hFFFF)) dut_w (
      .clk(clk), .reset(reset), .pc_in(16'h0000), .pc_load(1'b0),
      .mem_req(req_w), .mem_addr(addr_w), .mem_gnt(gnt_w),
      .mem_rvalid(rv_w), .mem_rdata(rd_w),
      .instruction(ins_w), .instr_valid(vld_w), .instr_ready(rdy_w)
`ifdef TRON_FETCH_PERF_EN
     ,.fetch_cnt(fetch_cnt_w), .stall_cnt(stall_cnt_w)
`endif
   );

   // Memory model: a granted request returns memf(addr) one cycle later.
   always @(posedge clk) begin
      logic        acc;
      logic [15:0] a;
      acc = mem_req && mem_gnt && auto_en && !reset;
      a   = mem_addr;
      #1;
      auto_rv = acc;
      auto_rd = acc ? memf(a) : 16'hDEAD;
   end

   always @(posedge clk) begin
      logic        acc;
      logic [15:0] a;
      acc = req_w && gnt_w && !reset;
      a   = addr_w;
      #1;
      rv_w = acc;
      rd_w = acc ? memf(a) : 16'hDEAD;
   end

   task automatic do_reset();
      reset = 1'b1; pc_load = 1'b0; man_rv = 1'b0; instr_ready = 1'b0; rdy_w = 1'b0;
      gnt_en = 1'b0; auto_en = 1'b0;
      exp_q.delete();
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; pc_load = 1'b0; pc_in = 16'h0; man_rv = 1'b0; man_rd = 16'h0;
      instr_ready = 1'b0; rdy_w = 1'b0; gnt_en = 1'b0; auto_en = 1'b0;
      @(negedge clk); @(negedge clk);
      n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
      n_chk++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid got %b want 0", instr_valid); end
      n_chk++; if (instruction !== NOP) begin n_fail++; $display("FAIL reset_instruction got %h want %h", instruction, NOP); end
      n_chk++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0000", mem_addr); end
      n_chk++; if (addr_w !== 16'hFFFF) begin n_fail++; $display("FAIL reset_pc_param got %h want FFFF", addr_w); end
`ifdef TRON_FETCH_PERF_EN
      n_chk++; if (fetch_cnt !== 16'h0 || stall_cnt !== 16'h0) begin
         n_fail++; $display("FAIL reset_perf got %h/%h want 0/0", fetch_cnt, stall_cnt); end
`endif
      reset = 1'b0;
   endtask

   task automatic test_stream();
      logic [15:0] ea, e;
      do_reset();
      gnt_en = 1'b1; auto_en = 1'b1; instr_ready = 1'b1;
      for (int i = 0; i < 8; i++) exp_q.push_back(memf(16'(i)));
      ea = 16'h0000;
      for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
         @(negedge clk);
         if (mem_req && mem_gnt) begin
            n_chk++; if (mem_addr !== ea) begin n_fail++; $display("FAIL stream_addr got %h want %h", mem_addr, ea); end
            ea = ea + 16'd1;
         end
         if (instr_valid && instr_ready) begin
            e = exp_q.pop_front();
            n_chk++; if (instruction !== e) begin n_fail++; $display("FAIL stream_data got %h want %h", instruction, e); end
         end
      end
      n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stream_timeout got %0d left want 0", exp_q.size()); end
   endtask

   task automatic test_backpressure();
      int ngnt;
      logic [15:0] e;
      do_reset();
      gnt_en = 1'b1; auto_en = 1'b1; instr_ready = 1'b0;
      ngnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (mem_req && mem_gnt) ngnt++;
      end
      n_chk++; if (ngnt != 2) begin n_fail++; $display("FAIL bp_fetches got %0d want 2", ngnt); end
      n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL bp_mem_req got %b want 0", mem_req); end
      n_chk++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got %b want 1", instr_valid); end
      n_chk++; if (instruction !== memf(16'h0)) begin n_fail++; $display("FAIL bp_head got %h want %h", instruction, memf(16'h0)); end
      for (int i = 0; i < 4; i++) exp_q.push_back(memf(16'(i)));
      instr_ready = 1'b1;
      for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
         if (instr_valid && instr_ready) begin
            e = exp_q.pop_front();
            n_chk++; if (instruction !== e) begin n_fail++; $display("FAIL bp_drain got %h want %h", instruction, e); end
         end
         @(negedge clk);
      end
      n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_timeout got %0d left want 0", exp_q.size()); end
   endtask

   task automatic test_flush();
      logic [15:0] e;
      do_reset();
      gnt_en = 1'b1; auto_en = 1'b1; instr_ready = 1'b0;
      repeat (10) @(negedge clk);
      pc_in = 16'h0040; pc_load = 1'b1;
      @(negedge clk);
      pc_load = 1'b0;
      n_chk++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", instr_valid); end
      n_chk++; if (instruction !== NOP) begin n_fail++; $display("FAIL flush_nop got %h want %h", instruction, NOP); end
      n_chk++; if (mem_req !== 1'b1 || mem_addr !== 16'h0040) begin
         n_fail++; $display("FAIL flush_req got %b/%h want 1/0040", mem_req, mem_addr); end
      exp_q.push_back(memf(16'h0040)); exp_q.push_back(memf(16'h0041));
      instr_ready = 1'b1;
      for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
         @(negedge clk);
         if (instr_valid && instr_ready) begin
            e = exp_q.pop_front();
            n_chk++; if (instruction !== e) begin n_fail++; $display("FAIL flush_data got %h want %h", instruction, e); end
         end
      end
      n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL flush_timeout got %0d left want 0", exp_q.size()); end
   endtask

   task automatic test_redirect();
      logic        seen;
      logic [15:0] e;
      do_reset();
      gnt_en = 1'b1; auto_en = 1'b0; instr_ready = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (mem_req && mem_gnt) seen = 1'b1;
      end
      n_chk++; if (!seen || mem_addr !== 16'h0000) begin
         n_fail++; $display("FAIL redir_first_req got %b/%h want 1/0000", seen, mem_addr); end
      @(negedge clk);              // now waiting on the read of address 0
      pc_in = 16'h0002; pc_load = 1'b1;
      @(negedge clk);
      pc_load = 1'b0;
      n_chk++; if (mem_req !== 1'b0 || mem_addr !== 16'h0002) begin
         n_fail++; $display("FAIL redir_drop_state got %b/%h want 0/0002", mem_req, mem_addr); end
      man_rd = 16'hBAD0; man_rv = 1'b1;   // late response to the abandoned read
      @(negedge clk);
      man_rv = 1'b0;
      n_chk++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_stale_pushed got %b want 0", instr_valid); end
      n_chk++; if (mem_req !== 1'b1 || mem_addr !== 16'h0002) begin
         n_fail++; $display("FAIL redir_next_req got %b/%h want 1/0002", mem_req, mem_addr); end
      auto_en = 1'b1;
      exp_q.push_back(memf(16'h0002)); exp_q.push_back(memf(16'h0003));
      for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
         @(negedge clk);
         if (instr_valid && instr_ready) begin
            e = exp_q.pop_front();
            n_chk++; if (instruction !== e) begin n_fail++; $display("FAIL redir_data got %h want %h", instruction, e); end
         end
      end
      n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL redir_timeout got %0d left want 0", exp_q.size()); end
   endtask

   task automatic test_reset_wait();
      logic        seen;
      logic [15:0] e;
      do_reset();
      gnt_en = 1'b1; auto_en = 1'b0; instr_ready = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (mem_req && mem_gnt) seen = 1'b1;
      end
      @(negedge clk);              // read of address 0 outstanding
      reset = 1'b1; gnt_en = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      man_rd = 16'hBAD1; man_rv = 1'b1;
      @(negedge clk);
      man_rv = 1'b0;
      n_chk++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rstw_valid got %b want 0", instr_valid); end
      n_chk++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
         n_fail++; $display("FAIL rstw_restart got %b/%h want 1/0000", mem_req, mem_addr); end
      @(negedge clk);
      n_chk++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rstw_valid2 got %b want 0", instr_valid); end
      gnt_en = 1'b1; auto_en = 1'b1;
      exp_q.push_back(memf(16'h0000)); exp_q.push_back(memf(16'h0001));
      for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
         @(negedge clk);
         if (instr_valid && instr_ready) begin
            e = exp_q.pop_front();
            n_chk++; if (instruction !== e) begin n_fail++; $display("FAIL rstw_data got %h want %h", instruction, e); end
         end
      end
      n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rstw_timeout got %0d left want 0", exp_q.size()); end
   endtask

   task automatic test_wrap();
      logic [15:0] ew, e;
      int ngnt;
      do_reset();
      rdy_w = 1'b1;
      exp_q.push_back(memf(16'hFFFF)); exp_q.push_back(memf(16'h0000));
      ew = 16'hFFFF; ngnt = 0;
      for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
         @(negedge clk);
         if (req_w && gnt_w && ngnt < 2) begin
            n_chk++; if (addr_w !== ew) begin n_fail++; $display("FAIL wrap_addr got %h want %h", addr_w, ew); end
            ew = ew + 16'd1; ngnt++;
         end
         if (vld_w && rdy_w) begin
            e = exp_q.pop_front();
            n_chk++; if (ins_w !== e) begin n_fail++; $display("FAIL wrap_data got %h want %h", ins_w, e); end
         end
      end
      n_chk++; if (exp_q.size() != 0 || ngnt != 2) begin
         n_fail++; $display("FAIL wrap_timeout got %0d left/%0d req want 0/2", exp_q.size(), ngnt); end
      rdy_w = 1'b0;
   endtask

`ifdef TRON_FETCH_PERF_EN
   task automatic test_perf();
      do_reset();
      gnt_en = 1'b1; auto_en = 1'b1; instr_ready = 1'b0;
      repeat (12) @(negedge clk);          // 2 fetches, buffer full
      gnt_en = 1'b0; instr_ready = 1'b1;
      repeat (5) @(negedge clk);           // 2 pops then 3 starved cycles
      instr_ready = 1'b0; gnt_en = 1'b1;
      repeat (12) @(negedge clk);          // 2 more fetches
      instr_ready = 1'b1;
      @(negedge clk);                      // one pop
      instr_ready = 1'b0;
      repeat (12) @(negedge clk);          // refill: fifth fetch
      n_chk++; if (fetch_cnt !== 16'd5) begin n_fail++; $display("FAIL perf_fetch got %0d want 5", fetch_cnt); end
      n_chk++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL perf_stall got %0d want 3", stall_cnt); end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_redirect();
      test_reset_wait();
      test_wrap();
`ifdef TRON_FETCH_PERF_EN
      test_perf();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
